// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared constants for the 74x163 counter
package ttl_pkg;

  localparam logic [3:0] TTL74X163_MAX = 4'b1111;

endpackage

// File: rtl/ttl74x163.sv
// rtl/ttl74x163.sv - 4-bit synchronous binary counter, sync clear, sync load, carry out
module ttl74x163
  import ttl_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic enp,
  input  logic ent,
  input  logic data_a,
  input  logic data_b,
  input  logic data_c,
  input  logic data_d,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd,
  output logic rco
);

  logic [3:0] count;

  // Clear wins over load, load over counting; an X on lower-priority controls is ignored while clear is low.
  always_ff @(posedge clk) begin
    if (!clear) begin
      count <= 4'b0000;
    end else if (!load) begin
      count <= {data_d, data_c, data_b, data_a};
    end else if (enp && ent) begin
      count <= count + 4'd1;
    end
  end

  assign {qd, qc, qb, qa} = count;

  // Carry is gated by ent only, so a cascaded stage sees it in the same cycle.
  assign rco = ent && (count == TTL74X163_MAX);

endmodule

// File: tb/tb_ttl74x163.sv
// tb/tb_ttl74x163.sv - self-checking bench for ttl74x163 with a behavioural model
module tb_ttl74x163;
  import ttl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear, load, enp, ent;
  logic [3:0] data;
  logic qa, qb, qc, qd, rco;

  logic c_clear, c_enp;
  logic c_qa0, c_qb0, c_qc0, c_qd0, c_rco0;
  logic c_qa1, c_qb1, c_qc1, c_qd1, c_rco1;

  int checks = 0;
  int failures = 0;
  int m_q = 0;
  int prev_val;
  int wraps;

  ttl74x163 dut (
    .clk(clk), .clear(clear), .load(load), .enp(enp), .ent(ent),
    .data_a(data[0]), .data_b(data[1]), .data_c(data[2]), .data_d(data[3]),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd), .rco(rco)
  );

  ttl74x163 low_stage (
    .clk(clk), .clear(c_clear), .load(1'b1), .enp(c_enp), .ent(1'b1),
    .data_a(1'b0), .data_b(1'b0), .data_c(1'b0), .data_d(1'b0),
    .qa(c_qa0), .qb(c_qb0), .qc(c_qc0), .qd(c_qd0), .rco(c_rco0)
  );

  ttl74x163 high_stage (
    .clk(clk), .clear(c_clear), .load(1'b1), .enp(c_enp), .ent(c_rco0),
    .data_a(1'b0), .data_b(1'b0), .data_c(1'b0), .data_d(1'b0),
    .qa(c_qa1), .qb(c_qb1), .qc(c_qc1), .qd(c_qd1), .rco(c_rco1)
  );

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic cl, input logic ld, input logic p, input logic t, input logic [3:0] d);
    clear = cl; load = ld; enp = p; ent = t; data = d;
  endtask

  function automatic int q_now();
    logic [3:0] v;
    v = {qd, qc, qb, qa};
    return (^v === 1'bx) ? -1 : int'(v);
  endfunction

  function automatic int rco_model();
    if (ent === 1'b1 && m_q == int'(TTL74X163_MAX)) return 1;
    return 0;
  endfunction

  // Advance the reference one edge from the current inputs, then compare after the edge.
  task automatic tick(input string tag);
    if (clear === 1'b0)            m_q = 0;
    else if (load === 1'b0)        m_q = int'(data);
    else if (enp === 1'b1 && ent === 1'b1) m_q = (m_q + 1) % 16;
    @(posedge clk);
    #1;
    check({tag, ".q"}, q_now(), m_q);
    check({tag, ".rco"}, int'(rco), rco_model());
  endtask

  task automatic rco_now(input string tag);
    #1;
    check({tag, ".rco_comb"}, int'(rco), rco_model());
  endtask

  initial begin
    c_clear = 1'b0; c_enp = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
    tick("reset");
    check("reset.q_zero", q_now(), 0);

    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      tick("count_wrap");
      check("count_wrap.seq", q_now(), (i + 1) % 16);
    end

    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0101);
    tick("load_0101");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1100);
    tick("load_prio");
    check("load_prio.value", q_now(), 12);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) tick("hold_enp0");
    check("hold_enp0.value", q_now(), 12);

    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111);
    tick("load_1111_rco");
    check("load_1111_rco.raised", int'(rco), 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    rco_now("ent_low");
    check("ent_low.rco_zero", int'(rco), 0);
    tick("hold_ent0");
    ent = 1'b1;
    rco_now("ent_high");
    check("ent_high.rco_one", int'(rco), 1);
    tick("wrap_from_max");
    check("wrap_from_max.q_zero", q_now(), 0);

    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0111);
    tick("load_0111");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick("count_to_8");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0111);
    tick("reload_0111");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick("mid_clear");
    check("mid_clear.q_zero", q_now(), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    tick("after_clear");
    check("after_clear.q_one", q_now(), 1);

    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111);
    tick("load_max");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110);
    tick("clear_at_max");
    check("clear_at_max.q_zero", q_now(), 0);
    drive(1'b0, 1'bx, 1'bx, 1'b1, 4'bxxxx);
    tick("clear_with_x");

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
            1'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
      rco_now("rand");
      tick("rand");
    end

    c_clear = 1'b1;
    #1;
    check("cascade.reset", int'({c_qd1, c_qc1, c_qb1, c_qa1, c_qd0, c_qc0, c_qb0, c_qa0}), 0);
    prev_val = 0;
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      check("cascade.step",
            int'({c_qd1, c_qc1, c_qb1, c_qa1, c_qd0, c_qc0, c_qb0, c_qa0}),
            (prev_val + 1) % 256);
      prev_val = (prev_val + 1) % 256;
      if (prev_val == 0) wraps++;
    end
    check("cascade.final", int'({c_qd1, c_qc1, c_qb1, c_qa1, c_qd0, c_qc0, c_qb0, c_qa0}), 300 % 256);
    check("cascade.wraps", wraps, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // The cascade pair is cleared by the first edge, concurrently with the directed sequence.
  initial begin
    @(posedge clk);
    #1;
    c_clear = 1'b0;
  end

endmodule
